// File: rtl/ft2232_pkt_engine_if.sv
// FIFO-side signals of the FT2232 packet engine.
// master: the engine (pops IN FIFO, pushes OUT FIFO); slave: the FIFO side.
interface ft2232_pkt_engine_if;
  logic       rd_in_fifo_en_o;
  logic [7:0] rd_in_fifo_data_i;
  logic       rd_in_fifo_empty_i;
  logic       wr_out_fifo_en_o;
  logic [7:0] wr_out_fifo_data_o;
  logic       wr_out_fifo_full_i;
  logic       wr_out_fifo_afull_i;

  modport master (
    output rd_in_fifo_en_o,
    input  rd_in_fifo_data_i,
    input  rd_in_fifo_empty_i,
    output wr_out_fifo_en_o,
    output wr_out_fifo_data_o,
    input  wr_out_fifo_full_i,
    input  wr_out_fifo_afull_i
  );

  modport slave (
    input  rd_in_fifo_en_o,
    output rd_in_fifo_data_i,
    output rd_in_fifo_empty_i,
    input  wr_out_fifo_en_o,
    input  wr_out_fifo_data_o,
    output wr_out_fifo_full_i,
    output wr_out_fifo_afull_i
  );
endinterface

// File: rtl/ft2232_pkt_engine.sv
// FT2232 packet engine: frames host bytes (SYNC CMD LEN payload CHK),
// executes PING/ECHO and pushes a framed response into the OUT FIFO.
// Optional packet statistics counters are built when PKT_STATS_EN is defined.
module ft2232_pkt_engine #(
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  ft2232_pkt_engine_if.master fifo,
  output logic                busy_o
`ifdef PKT_STATS_EN
  ,
  output logic [15:0]         pkt_ok_count_o,
  output logic [15:0]         pkt_err_count_o
`endif
);

  localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK,
    ST_TX_SYNC, ST_TX_CMD, ST_TX_LEN, ST_TX_DATA, ST_TX_CHK
  } state_e;

  state_e     state_q, state_d;
  logic       vld_q, vld_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d, sum_q, sum_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, req_cnt_q, req_cnt_d;
  logic [7:0] rcmd_q, rcmd_d, rlen_q, rlen_d, tsum_q, tsum_d, tx_cnt_q, tx_cnt_d;

  logic [7:0]    pay_mem [MAX_PAYLOAD];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;

  logic       rx_state, pop_ok, pop, push;
  logic [7:0] rx_byte, tx_byte;

  assign rx_byte                 = fifo.rd_in_fifo_data_i;
  assign fifo.rd_in_fifo_en_o    = pop;
  assign fifo.wr_out_fifo_en_o   = push;
  assign fifo.wr_out_fifo_data_o = tx_byte;
  assign busy_o                  = (state_q != ST_HUNT);

  // Pop/push qualification and the byte offered to the OUT FIFO
  always_comb begin
    rx_state = (state_q == ST_HUNT) || (state_q == ST_CMD) || (state_q == ST_LEN) ||
               (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // Header/CHK fields keep at most one byte in flight; payload streams
    // until the last byte has been requested.
    if (state_q == ST_PAYLOAD) pop_ok = (req_cnt_q < len_q);
    else                       pop_ok = rx_state && !vld_q;
    pop  = pop_ok && !fifo.rd_in_fifo_empty_i && !reset_i;
    push = !rx_state && !fifo.wr_out_fifo_afull_i && !fifo.wr_out_fifo_full_i;
    case (state_q)
      ST_TX_SYNC: tx_byte = SYNC_BYTE;
      ST_TX_CMD:  tx_byte = rcmd_q;
      ST_TX_LEN:  tx_byte = rlen_q;
      ST_TX_DATA: tx_byte = pay_mem[tx_cnt_q[AW-1:0]];
      ST_TX_CHK:  tx_byte = tsum_q;
      default:    tx_byte = '0;
    endcase
  end

  // Next-state and datapath decisions for receive and response framing
  always_comb begin
    state_d   = state_q;
    vld_d     = pop;
    cmd_d     = cmd_q;
    len_d     = len_q;
    sum_d     = sum_q;
    rx_cnt_d  = rx_cnt_q;
    req_cnt_d = req_cnt_q;
    rcmd_d    = rcmd_q;
    rlen_d    = rlen_q;
    tsum_d    = tsum_q;
    tx_cnt_d  = tx_cnt_q;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wd    = rx_byte;
    case (state_q)
      ST_HUNT: if (vld_q && rx_byte == SYNC_BYTE) state_d = ST_CMD;
      ST_CMD: if (vld_q) begin
        cmd_d   = rx_byte;
        sum_d   = rx_byte;
        state_d = ST_LEN;
      end
      ST_LEN: if (vld_q) begin
        len_d     = rx_byte;
        sum_d     = sum_q + rx_byte;
        rx_cnt_d  = '0;
        req_cnt_d = '0;
        if (rx_byte > MAX_LEN)      state_d = ST_HUNT;
        else if (rx_byte == 8'd0)   state_d = ST_CHK;
        else                        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (pop) req_cnt_d = req_cnt_q + 8'd1;
        if (vld_q) begin
          mem_we   = 1'b1;
          mem_wa   = rx_cnt_q[AW-1:0];
          sum_d    = sum_q + rx_byte;
          rx_cnt_d = rx_cnt_q + 8'd1;
          if (rx_cnt_q == len_q - 8'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: if (vld_q) begin
        state_d  = ST_TX_SYNC;
        tx_cnt_d = '0;
        if (rx_byte != sum_q) begin
          rcmd_d = 8'hFE;
          rlen_d = 8'd0;
        end else if (cmd_q == 8'h02) begin
          rcmd_d = 8'h82;
          rlen_d = 8'd0;
        end else if (cmd_q == 8'h01) begin
          rcmd_d = 8'h81;
          rlen_d = len_q;
        end else begin
          // The NAK_CMD echo byte goes through the payload buffer so that
          // TX_DATA has a single source.
          rcmd_d = 8'hFF;
          rlen_d = 8'd1;
          mem_we = 1'b1;
          mem_wa = '0;
          mem_wd = cmd_q;
        end
        tsum_d = rcmd_d + rlen_d;
      end
      ST_TX_SYNC: if (push) state_d = ST_TX_CMD;
      ST_TX_CMD:  if (push) state_d = ST_TX_LEN;
      ST_TX_LEN:  if (push) state_d = (rlen_q == 8'd0) ? ST_TX_CHK : ST_TX_DATA;
      ST_TX_DATA: if (push) begin
        tsum_d   = tsum_q + tx_byte;
        tx_cnt_d = tx_cnt_q + 8'd1;
        if (tx_cnt_q == rlen_q - 8'd1) state_d = ST_TX_CHK;
      end
      ST_TX_CHK:  if (push) state_d = ST_HUNT;
      default:    state_d = ST_HUNT;
    endcase
  end

  // Engine state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_HUNT;
      vld_q     <= 1'b0;
      cmd_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      rx_cnt_q  <= '0;
      req_cnt_q <= '0;
      rcmd_q    <= '0;
      rlen_q    <= '0;
      tsum_q    <= '0;
      tx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      rx_cnt_q  <= rx_cnt_d;
      req_cnt_q <= req_cnt_d;
      rcmd_q    <= rcmd_d;
      rlen_q    <= rlen_d;
      tsum_q    <= tsum_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (mem_we) pay_mem[mem_wa] <= mem_wd;
  end

`ifdef PKT_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic        resp_ok, resp_err;

  // Classify finished requests and step the saturating counters
  always_comb begin
    resp_ok  = vld_q && (state_q == ST_CHK) && (rx_byte == sum_q) &&
               ((cmd_q == 8'h01) || (cmd_q == 8'h02));
    resp_err = vld_q && (((state_q == ST_CHK) && !resp_ok) ||
                         ((state_q == ST_LEN) && (rx_byte > MAX_LEN)));
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (resp_ok  && ok_cnt_q  != '1) ok_cnt_d  = ok_cnt_q  + 16'd1;
    if (resp_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_ok_count_o  = ok_cnt_q;
  assign pkt_err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ft2232_pkt_engine.sv
// Self-checking bench for ft2232_pkt_engine: a queue-backed FIFO pair and a
// stream-scanning reference model of the packet protocol.
module tb_ft2232_pkt_engine;
  localparam int MAXP = 16;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  ft2232_pkt_engine_if ifc ();
`ifdef PKT_STATS_EN
  logic [15:0] ok_cnt, err_cnt;
`endif

  ft2232_pkt_engine #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .fifo    (ifc),
    .busy_o  (busy)
`ifdef PKT_STATS_EN
    ,
    .pkt_ok_count_o  (ok_cnt),
    .pkt_err_count_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  bq_t in_q, exp_q, pk;
  int  push_cyc [$];
  int  checks = 0, errors = 0, cyc = 0;
  bit  stall_en = 1'b0, bp_en = 1'b0, bp_arm = 1'b0;
  int  afull_hold = 0;
  int  exp_ok = 0, exp_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: scan a byte stream for complete packets and build the responses.
  task automatic model(input bq_t s, output bq_t r, output int nok, output int nerr);
    int i, n, L;
    logic [7:0] cmd, len, sum, rc, rl, cs;
    bq_t pl;
    r = {}; nok = 0; nerr = 0; i = 0; n = s.size();
    while (i < n) begin
      if (s[i] != 8'hA5) begin i++; continue; end
      if (i + 2 >= n) break;
      cmd = s[i+1]; len = s[i+2]; L = int'(len);
      if (L > MAXP) begin nerr++; i += 3; continue; end
      if (i + 3 + L >= n) break;
      sum = cmd + len;
      for (int k = 0; k < L; k++) sum = sum + s[i+3+k];
      pl = {};
      if (s[i+3+L] != sum)  begin rc = 8'hFE; rl = 8'd0; nerr++; end
      else if (cmd == 8'h02) begin rc = 8'h82; rl = 8'd0; nok++; end
      else if (cmd == 8'h01) begin
        rc = 8'h81; rl = len; nok++;
        for (int k = 0; k < L; k++) pl.push_back(s[i+3+k]);
      end else begin rc = 8'hFF; rl = 8'd1; pl.push_back(cmd); nerr++; end
      cs = rc + rl;
      r.push_back(8'hA5); r.push_back(rc); r.push_back(rl);
      foreach (pl[k]) begin r.push_back(pl[k]); cs = cs + pl[k]; end
      r.push_back(cs);
      i += 4 + L;
    end
  endtask

  // FIFO pair: sample DUT at negedge, update FIFO-side inputs just after posedge.
  initial begin : fifo_side
    bit p;
    logic [7:0] e;
    ifc.rd_in_fifo_data_i  = '0;
    ifc.rd_in_fifo_empty_i = 1'b1;
    ifc.wr_out_fifo_full_i = 1'b0;
    ifc.wr_out_fifo_afull_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      p = 1'b0;
      if (!rst) begin
        if (ifc.rd_in_fifo_en_o) begin
          check("pop_when_empty", ifc.rd_in_fifo_empty_i, 0);
          p = !ifc.rd_in_fifo_empty_i;
        end
        if (ifc.wr_out_fifo_en_o) begin
          check("push_when_afull_or_full", {ifc.wr_out_fifo_afull_i, ifc.wr_out_fifo_full_i}, 0);
          check("pop_during_push", ifc.rd_in_fifo_en_o, 0);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_push: got %02h, no byte expected (cycle %0d)",
                     ifc.wr_out_fifo_data_o, cyc);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", ifc.wr_out_fifo_data_o, e);
          end
          push_cyc.push_back(cyc);
          if (bp_arm) begin bp_arm = 1'b0; afull_hold = 5; end
        end
      end
      @(posedge clk);
      #1;
      if (p && in_q.size() > 0) ifc.rd_in_fifo_data_i = in_q.pop_front();
      if (afull_hold > 0) begin ifc.wr_out_fifo_afull_i = 1'b1; afull_hold--; end
      else ifc.wr_out_fifo_afull_i = bp_en && ($urandom_range(0, 3) == 0);
      ifc.wr_out_fifo_full_i  = bp_en && ($urandom_range(0, 7) == 0);
      ifc.rd_in_fifo_empty_i  = (in_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (in_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s_idle: timeout with %0d input bytes and %0d expected bytes left",
               name, in_q.size(), exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_pkt(input string name, input bq_t s, input bq_t lit, input bit use_lit);
    bq_t r;
    int nok, nerr;
    model(s, r, nok, nerr);
    if (use_lit) begin
      check({name, "_model_len"}, r.size(), lit.size());
      foreach (lit[k]) if (k < r.size()) check({name, "_model_byte"}, r[k], lit[k]);
    end
    exp_ok += nok; exp_err += nerr;
    foreach (r[k]) exp_q.push_back(r[k]);
    foreach (s[k]) in_q.push_back(s[k]);
    wait_idle(name);
`ifdef PKT_STATS_EN
    check({name, "_ok_count"}, ok_cnt, exp_ok);
    check({name, "_err_count"}, err_cnt, exp_err);
`endif
  endtask

  task automatic add_pkt(input logic [7:0] cmd, input int len, input bit bad);
    logic [7:0] sum, b;
    pk.push_back(8'hA5); pk.push_back(cmd); pk.push_back(8'(len));
    sum = cmd + 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      pk.push_back(b);
      sum = sum + b;
    end
    if (bad) sum = sum + 8'($urandom_range(1, 255));
    pk.push_back(sum);
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      pk.push_back(b);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_pop"}, ifc.rd_in_fifo_en_o, 0);
    check({name, "_push"}, ifc.wr_out_fifo_en_o, 0);
    check({name, "_data"}, ifc.wr_out_fifo_data_o, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin : main
    bq_t s, lit;
    int n;
    // Reset with a byte available: no pop may be issued.
    in_q.push_back(8'h00);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;

    s = '{8'hA5, 8'h02, 8'h00, 8'h02}; lit = '{8'hA5, 8'h82, 8'h00, 8'h82};
    run_pkt("ping", s, lit, 1'b1);
    check("ping_busy_after", busy, 0);

    push_cyc.delete();
    s = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    lit = '{8'hA5, 8'h81, 8'h03, 8'h11, 8'h22, 8'h33, 8'hEA};
    run_pkt("echo", s, lit, 1'b1);
    check("echo_push_count", push_cyc.size(), 7);
    if (push_cyc.size() == 7) check("echo_push_span", push_cyc[6] - push_cyc[0], 6);

    s = '{8'hA5, 8'h02, 8'h00, 8'h03}; lit = '{8'hA5, 8'hFE, 8'h00, 8'hFE};
    run_pkt("bad_chk", s, lit, 1'b1);

    s = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07};
    lit = '{8'hA5, 8'hFF, 8'h01, 8'h07, 8'h07};
    run_pkt("unknown_cmd", s, lit, 1'b1);

    s = '{8'hA5, 8'h01, 8'h20};
    for (int k = 0; k < 32; k++) s.push_back(8'(k));
    s.push_back(8'hA5); s.push_back(8'h02); s.push_back(8'h00); s.push_back(8'h02);
    lit = '{8'hA5, 8'h82, 8'h00, 8'h82};
    run_pkt("overflow", s, lit, 1'b1);

    s = '{8'hA5, 8'h01, 8'h00, 8'h01}; lit = '{8'hA5, 8'h81, 8'h00, 8'h81};
    run_pkt("echo_len0", s, lit, 1'b1);

    pk.delete(); add_pkt(8'h01, MAXP, 1'b0);
    lit = {};
    run_pkt("echo_max", pk, lit, 1'b0);

    s = '{8'hA5, 8'h01, 8'h11, 8'h00, 8'hA5, 8'h02, 8'h00, 8'h02};
    lit = '{8'hA5, 8'h82, 8'h00, 8'h82};
    run_pkt("len_max_plus1", s, lit, 1'b1);

    // Backpressure: afull held for 5 cycles right after the first push.
    push_cyc.delete(); bp_arm = 1'b1;
    s = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    lit = '{8'hA5, 8'h81, 8'h03, 8'h11, 8'h22, 8'h33, 8'hEA};
    run_pkt("echo_bp", s, lit, 1'b1);
    check("echo_bp_push_count", push_cyc.size(), 7);
    if (push_cyc.size() == 7) check("echo_bp_push_span", push_cyc[6] - push_cyc[0], 11);

    // Reset in the middle of a payload.
    in_q = '{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02, 8'h03};
    n = 0;
    while (in_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("mid_payload_drain_timeout", (n >= 200), 0);
    repeat (3) @(negedge clk);
    check("busy_mid_payload", busy, 1);
    @(posedge clk); #2 rst = 1'b1;
    in_q.delete(); exp_q.delete(); exp_ok = 0; exp_err = 0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #2 rst = 1'b0;
    s = '{8'hA5, 8'h02, 8'h00, 8'h02}; lit = '{8'hA5, 8'h82, 8'h00, 8'h82};
    run_pkt("ping_after_reset", s, lit, 1'b1);

    // Randomized traffic with input stalls and output backpressure.
    stall_en = 1'b1; bp_en = 1'b1; pk.delete();
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 5))
        0: add_pkt(8'h02, 0, 1'b0);
        1: add_pkt(8'h01, $urandom_range(0, MAXP), 1'b0);
        2: add_pkt(8'($urandom_range(0, 3)), $urandom_range(0, MAXP), 1'b1);
        3: add_pkt(8'($urandom_range(3, 255)), $urandom_range(0, 4), 1'b0);
        4: begin
          pk.push_back(8'hA5); pk.push_back(8'h01);
          pk.push_back(8'($urandom_range(MAXP + 1, 255)));
        end
        default: add_garbage(3);
      endcase
      add_garbage($urandom_range(0, 2));
    end
    lit = {};
    run_pkt("random", pk, lit, 1'b0);
    stall_en = 1'b0; bp_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
